// File: rtl/nx_srfram_arb_pkg.sv
// Shared types and helpers for the SRFRAM hardware-port arbiter.
//   arb_rsp_tag_t : {valid, id} carried down the read-return pipeline.
//   arb_id_w()    : requester-ID width for a given requester count.
// The tag ID field is sized for the largest supported requester count (8).
package nx_srfram_arb_pkg;

    localparam int ARB_ID_W_MAX = 3;

    typedef struct packed {
        logic                    valid;
        logic [ARB_ID_W_MAX-1:0] id;
    } arb_rsp_tag_t;

    function automatic int arb_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nx_rr_pick.sv
// Combinational rotate-priority picker.
//   req    : request vector
//   ptr    : index with highest priority this cycle
//   gnt    : one-hot grant (subset of req)
//   gnt_id : encoded grant index
//   any    : some request present
module nx_rr_pick
    import nx_srfram_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = arb_id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             any
);

    always_comb begin
        int j;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr < N_REQ, so a single subtraction implements the wrap.
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                gnt_id = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/nx_srfram_hw_arbiter.sv
// Round-robin arbiter sharing the hardware port of an indirect-access
// single-read/single-write RAM among N_REQ requesters. Software access
// pending in the RAM controller (hw_yield) blocks hardware grants.
//
// Optional feature macro: NX_SRFRAM_ARB_DENY_LIMIT_EN
//   When defined, after MAX_DENY consecutive yield-blocked cycles with a
//   pending request, one grant is forced through despite hw_yield.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/we        : per-requester request and write flag
//   req_addr/wdat       : flattened per-requester address / write data
//   req_ready           : one-hot grant (combinational)
//   rsp_valid/id/dat    : read return, tagged with requester ID
//   hw_cs/we/re         : registered RAM controls
//   hw_raddr/waddr/din  : registered RAM address (same value) and data
//   hw_dout, hw_yield   : RAM read data, software-pending indication
module nx_srfram_hw_arbiter
    import nx_srfram_arb_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int N_DATA_BITS = 32,
    parameter  int N_ENTRIES   = 1024,
    parameter  int RD_LATENCY  = 1,
    parameter  int MAX_DENY    = 8,
    localparam int AW          = $clog2(N_ENTRIES),
    localparam int IDW         = arb_id_w(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_we,
    input  logic [N_REQ*AW-1:0]          req_addr,
    input  logic [N_REQ*N_DATA_BITS-1:0] req_wdat,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         rsp_valid,
    output logic [IDW-1:0]               rsp_id,
    output logic [N_DATA_BITS-1:0]       rsp_dat,
    output logic                         hw_cs,
    output logic                         hw_we,
    output logic                         hw_re,
    output logic [AW-1:0]                hw_raddr,
    output logic [AW-1:0]                hw_waddr,
    output logic [N_DATA_BITS-1:0]       hw_din,
    input  logic [N_DATA_BITS-1:0]       hw_dout,
    input  logic                         hw_yield
);

    logic [IDW-1:0]         ptr;
    logic [N_REQ-1:0]       gnt;
    logic [IDW-1:0]         gnt_id;
    logic                   any;
    logic                   blocked;
    logic                   grant;
    logic                   sel_we;
    logic [AW-1:0]          sel_addr;
    logic [N_DATA_BITS-1:0] sel_wdat;
    logic [IDW-1:0]         next_ptr;
    arb_rsp_tag_t           tag_pipe [RD_LATENCY:0];

    nx_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

`ifdef NX_SRFRAM_ARB_DENY_LIMIT_EN
    localparam int DCW = $clog2(MAX_DENY + 1);
    logic [DCW-1:0] deny_cnt;

    // At the limit, this cycle's grant ignores hw_yield.
    assign blocked = hw_yield && (int'(deny_cnt) != MAX_DENY);

    always_ff @(posedge clk) begin
        if (rst || grant || !(|req_valid))
            deny_cnt <= '0;
        else if (blocked)
            deny_cnt <= deny_cnt + 1'b1;
    end
`else
    // Software strictly preempts hardware; MAX_DENY has no role here.
    logic unused_max_deny;
    assign unused_max_deny = |MAX_DENY;
    assign blocked         = hw_yield;
`endif

    assign grant     = any && !blocked && !rst;
    assign req_ready = grant ? gnt : '0;

    assign sel_we   = req_we[gnt_id];
    assign sel_addr = req_addr[int'(gnt_id)*AW +: AW];
    assign sel_wdat = req_wdat[int'(gnt_id)*N_DATA_BITS +: N_DATA_BITS];
    assign next_ptr = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            hw_cs    <= 1'b0;
            hw_we    <= 1'b0;
            hw_re    <= 1'b0;
            hw_raddr <= '0;
            hw_waddr <= '0;
            hw_din   <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) tag_pipe[k] <= '0;
        end else begin
            hw_cs <= grant;
            hw_we <= grant && sel_we;
            hw_re <= grant && !sel_we;
            if (grant) begin
                ptr      <= next_ptr;
                hw_raddr <= sel_addr;
                hw_waddr <= sel_addr;
                hw_din   <= sel_wdat;
            end
            // Stage 0 lines up with hw_re; the last stage with hw_dout.
            tag_pipe[0].valid <= grant && !sel_we;
            tag_pipe[0].id    <= ARB_ID_W_MAX'(gnt_id);
            for (int k = 1; k <= RD_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign rsp_valid = tag_pipe[RD_LATENCY].valid;
    assign rsp_id    = tag_pipe[RD_LATENCY].id[IDW-1:0];
    assign rsp_dat   = hw_dout;

    // Upper ID bits are spare when N_REQ < 8.
    logic unused_tag_id;
    assign unused_tag_id = ^tag_pipe[RD_LATENCY].id;

endmodule

// File: tb/tb_nx_srfram_hw_arbiter.sv
module tb_nx_srfram_hw_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 32;
    localparam int AW    = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid, req_we, req_ready;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdat;
    logic                rsp_valid;
    logic [1:0]          rsp_id;
    logic [DW-1:0]       rsp_dat;
    logic                hw_cs, hw_we, hw_re, hw_yield;
    logic [AW-1:0]       hw_raddr, hw_waddr;
    logic [DW-1:0]       hw_din, hw_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nx_srfram_hw_arbiter #(
        .N_REQ(N_REQ), .N_DATA_BITS(DW), .N_ENTRIES(1024), .RD_LATENCY(1), .MAX_DENY(8)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdat(req_wdat), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dat(rsp_dat),
        .hw_cs(hw_cs), .hw_we(hw_we), .hw_re(hw_re), .hw_raddr(hw_raddr),
        .hw_waddr(hw_waddr), .hw_din(hw_din), .hw_dout(hw_dout), .hw_yield(hw_yield)
    );

    // RAM model, read latency 1; every word preloaded with 0xA5A5_0000 | addr.
    logic [DW-1:0] mem [0:1023];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 1024; a++) mem[a] <= 32'hA5A50000 | a;
            mem_init <= 1'b1;
        end else begin
            if (hw_cs && hw_we) mem[hw_waddr] <= hw_din;
            if (hw_cs && hw_re) hw_dout <= mem[hw_raddr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_we = '0; hw_yield = 1'b0;
        #1;
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        step(); step();
        total++; if (hw_cs !== 1'b0) begin bad++; $display("FAIL reset_cs got %b want 0", hw_cs); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp got %b want 0", rsp_valid); end
        total++; if (hw_raddr !== 10'h0 || hw_din !== 32'h0) begin bad++; $display("FAIL reset_regs got %h/%h want 0/0", hw_raddr, hw_din); end
        rst = 1'b0; req_valid = '0;
        step();
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        req_valid = 4'hF; req_we = '0;
        for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = 10'(16 + i);
        for (int c = 0; c < 6; c++) begin
            if (c == 4) req_valid = '0;
            #1;
            exp_g = (c < 4) ? (4'b0001 << c) : 4'b0000;
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rot_ready c=%0d got %b want %b", c, req_ready, exp_g); end
            if (c >= 1 && c <= 4) begin
                total++;
                if (hw_cs !== 1'b1 || hw_re !== 1'b1 || hw_raddr !== 10'(15 + c)) begin
                    bad++; $display("FAIL rot_ram c=%0d got cs=%b re=%b a=%h want 1 1 %h", c, hw_cs, hw_re, hw_raddr, 10'(15 + c));
                end
            end
            if (c >= 2) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(c - 2) || rsp_dat !== 32'hA5A50010 + 32'(c - 2)) begin
                    bad++; $display("FAIL rot_rsp c=%0d got v=%b id=%0d d=%h want 1 %0d %h", c, rsp_valid, rsp_id, rsp_dat, c - 2, 32'hA5A50010 + 32'(c - 2));
                end
            end
            step();
        end
    endtask

    task automatic test_write_read();
        req_valid = 4'b0100; req_we = 4'b0100;
        req_addr[2*AW +: AW] = 10'h3FF; req_wdat[2*DW +: DW] = 32'hDEADBEEF;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wr_ready got %b want 0100", req_ready); end
        step();
        req_we = 4'b0000;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rd_ready got %b want 0100", req_ready); end
        total++;
        if (hw_cs !== 1'b1 || hw_we !== 1'b1 || hw_re !== 1'b0 || hw_waddr !== 10'h3FF || hw_raddr !== 10'h3FF || hw_din !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_ram got cs=%b we=%b re=%b wa=%h ra=%h din=%h want 1 1 0 3ff 3ff deadbeef", hw_cs, hw_we, hw_re, hw_waddr, hw_raddr, hw_din);
        end
        step();
        req_valid = '0;
        #1;
        total++; if (hw_re !== 1'b1 || hw_we !== 1'b0) begin bad++; $display("FAIL rd_ram got re=%b we=%b want 1 0", hw_re, hw_we); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_norsp got %b want 0", rsp_valid); end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_dat !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_rsp got v=%b id=%0d d=%h want 1 2 deadbeef", rsp_valid, rsp_id, rsp_dat);
        end
        step();
    endtask

    task automatic test_yield();
        req_valid = 4'b0010; req_we = '0; hw_yield = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (req_ready !== 4'b0000 || hw_cs !== 1'b0) begin bad++; $display("FAIL yield_block c=%0d got rdy=%b cs=%b want 0000 0", c, req_ready, hw_cs); end
            step();
        end
        hw_yield = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010 || hw_cs !== 1'b0) begin bad++; $display("FAIL yield_release got rdy=%b cs=%b want 0010 0", req_ready, hw_cs); end
        step();
        req_valid = '0;
        #1;
        total++; if (hw_cs !== 1'b1 || hw_re !== 1'b1 || hw_raddr !== 10'h011) begin bad++; $display("FAIL yield_ram got cs=%b re=%b a=%h want 1 1 011", hw_cs, hw_re, hw_raddr); end
        step();
    endtask

    task automatic test_deny();
        logic [3:0] exp_g;
        req_valid = 4'b0001; req_we = '0; hw_yield = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            #1;
`ifdef NX_SRFRAM_ARB_DENY_LIMIT_EN
            exp_g = (c == 9) ? 4'b0001 : 4'b0000;
`else
            exp_g = 4'b0000;
`endif
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL deny c=%0d got %b want %b", c, req_ready, exp_g); end
            step();
        end
        hw_yield = 1'b0; req_valid = '0;
        step();
    endtask

    task automatic test_wrap();
        logic [3:0] exp_g;
        req_valid = 4'b1001; req_we = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_g = (c % 2 == 0) ? 4'b1000 : 4'b0001;
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL wrap c=%0d got %b want %b", c, req_ready, exp_g); end
            step();
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        // Pointer sits at 1 after the wrap test.
        req_valid = 4'b0010; req_we = '0; req_addr[1*AW +: AW] = 10'h020;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rmid_grant got %b want 0010", req_ready); end
        step();
        rst = 1'b1; req_valid = 4'hF;
        #1;
        total++; if (req_ready !== 4'b0000 || hw_cs !== 1'b1) begin bad++; $display("FAIL rmid_inrst got rdy=%b cs=%b want 0000 1", req_ready, hw_cs); end
        step();
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ptr got %b want 0001", req_ready); end
        total++; if (rsp_valid !== 1'b0 || hw_cs !== 1'b0) begin bad++; $display("FAIL rmid_flush got v=%b cs=%b want 0 0", rsp_valid, hw_cs); end
        step();
        req_valid = '0;
        #1;
        total++; if (rsp_valid !== 1'b0 || hw_cs !== 1'b1 || hw_raddr !== 10'h010) begin bad++; $display("FAIL rmid_after got v=%b cs=%b a=%h want 0 1 010", rsp_valid, hw_cs, hw_raddr); end
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_dat !== 32'hA5A50010) begin bad++; $display("FAIL rmid_rsp got v=%b id=%0d d=%h want 1 0 a5a50010", rsp_valid, rsp_id, rsp_dat); end
        step();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdat = '0; hw_yield = 1'b0;
        step();
        test_reset();
        test_rotation();
        test_write_read();
        test_yield();
        test_deny();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nx_srfram_hw_arbiter.md
# nx_srfram_hw_arbiter

Round-robin arbiter that shares the hardware port of one indirect-access single-read/single-write RAM (`hw_cs`/`hw_*` side) among `N_REQ` hardware requesters. It also honours the RAM's `hw_yield`, so software indirect commands (grant = `!hw_cs`) are never locked out. Each granted read returns its data tagged with the requester ID. It sits between datapath clients and the RAM wrapper, inside the same clock domain.

## Interface
- `N_REQ`, 4: number of hardware requesters, 2..8.
- `N_DATA_BITS`, 32: RAM word width.
- `N_ENTRIES`, 1024: RAM depth; `AW = clog2(N_ENTRIES)`.
- `RD_LATENCY`, 1: RAM cycles from registered `hw_re` to valid `hw_dout`.
- `MAX_DENY`, 8: deny-limit threshold; used only with `NX_SRFRAM_ARB_DENY_LIMIT_EN`.
- `clk`  in  1  the block's one clock.
- `rst`  in  1  reset, **synchronous, active-high**.
- `req_valid`  in  N_REQ  per-requester access request.
- `req_we`  in  N_REQ  1 = write, 0 = read.
- `req_addr`  in  N_REQ*AW  flattened addresses; requester i at `[i*AW +: AW]`.
- `req_wdat`  in  N_REQ*N_DATA_BITS  flattened write data.
- `req_ready`  out  N_REQ  one-hot grant; the request is accepted in the cycle where `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  read data valid.
- `rsp_id`  out  clog2(N_REQ)  requester that issued the read.
- `rsp_dat`  out  N_DATA_BITS  read data (pass-through of `hw_dout`).
- `hw_cs`, `hw_we`, `hw_re`  out  1  registered RAM hardware controls.
- `hw_raddr`, `hw_waddr`  out  AW  registered RAM addresses; both carry the same value.
- `hw_din`  out  N_DATA_BITS  registered write data.
- `hw_dout`  in  N_DATA_BITS  RAM read data.
- `hw_yield`  in  1  software access pending in the RAM controller.

## Operation
- **Grant (combinational, cycle t).**
  - Block when `hw_yield=1`, subject to the deny limit described under Configuration.
  - Otherwise scan `req_valid` starting at pointer `ptr` and wrapping modulo N_REQ; the first set bit `g` gets `req_ready[g]=1`.
  - At most one grant per cycle. `req_ready` is 0 wherever `req_valid` is 0.
- **Pointer.**
  - On a grant to `g`, `ptr <= (g+1) mod N_REQ`.
  - With no grant, `ptr` holds.
- **RAM drive (registered, cycle t+1).**
  - `hw_cs=1`, `hw_we=req_we[g]`, `hw_re=~req_we[g]`.
  - Both addresses = `req_addr[g]`; `hw_din = req_wdat[g]`.
  - With no grant, `hw_cs=hw_we=hw_re=0`. Address and data hold their previous values.
- **Read return.**
  - A shift pipeline of depth 1+RD_LATENCY carries `{valid, id}`.
  - A read granted at t gives `rsp_valid=1`, `rsp_id=g` and `rsp_dat=hw_dout` at t+1+RD_LATENCY.
  - Writes produce no response.
  - Pipelined reads return in grant order, one per cycle, with no backpressure.
- **Write/read ordering.** Ordering to the same address follows grant order; the RAM resolves collisions.

## Timing
- **Reset values.** `rst=1` at a clock edge clears `ptr=0`, all RAM controls and addresses, `hw_din`, the response pipeline and the deny counter.
- **Outputs during reset.** `req_ready=0` while `rst=1`. `rsp_valid=0` in the cycle after reset.
- **Reset mid-operation.** In-flight reads are discarded with no `rsp_valid`. The RAM sees `hw_cs=0` from the cycle after reset is sampled.
- **Accept-to-RAM latency:** 1 cycle.
- **Read latency:** 1+RD_LATENCY cycles from grant to `rsp_valid`.
- **Throughput:** one access per cycle while `hw_yield=0`.
- **Yield onset.** `hw_yield` rising in cycle t blocks the grant in t, so `hw_cs=0` in t+1. An access granted in t-1 still completes at t.
- **All requesters valid.** Service order is strict rotation 0,1,2,3,0,…
- **Single requester valid.** That requester is granted every unblocked cycle.

## Configuration
- **Macro:** `NX_SRFRAM_ARB_DENY_LIMIT_EN`.
- **Defined:**
  - Counter `deny_cnt`, width `clog2(MAX_DENY+1)`.
  - Increments each cycle where any `req_valid=1` and the grant is blocked by `hw_yield`.
  - When `deny_cnt==MAX_DENY`, the grant proceeds despite `hw_yield` for that cycle.
  - Clears on any grant, on a cycle with no `req_valid`, and on reset.
- **Not defined:**
  - No counter exists.
  - `hw_yield=1` always blocks, so software strictly preempts hardware.

## Structure
- **Shared package** `nx_srfram_arb_pkg`:
  - `arb_rsp_tag_t` struct `{valid, id}`.
  - Localparam helpers for the ID width.
- **Sub-module** `nx_rr_pick`:
  - Combinational rotate-priority picker.
  - Inputs: `req[N_REQ]`, `ptr`. Outputs: one-hot `gnt` and encoded `gnt_id`.
  - Instantiated once.

## Test plan
- **Rotation.** All four `req_valid=1`, reads to addresses 0x10–0x13 with `hw_yield=0` → grants in order 0,1,2,3. Responses arrive at t+2 (RD_LATENCY=1) with `rsp_id` 0,1,2,3 and the matching data.
- **Write then read.** Requester 2 writes 0xDEADBEEF to 0x3FF, then reads 0x3FF → `hw_we=1` one cycle after acceptance. Read returns 0xDEADBEEF with `rsp_id=2`.
- **Yield preempt.** `hw_yield=1` for 5 cycles while requester 1 is valid → `req_ready=0` and `hw_cs=0` for those 5 cycles, plus 1 lagging cycle on `hw_cs`. Requester 1 is granted in the first cycle `hw_yield=0`.
- **Deny limit (macro defined, `MAX_DENY=8`).** `hw_yield` held at 1 with requester 0 valid → grant on the 9th blocked cycle, then the counter clears. With the macro undefined: no grant.
- **Pointer wrap.** Only requesters 3 and 0 valid → alternating 3,0,3,0.
- **Reset mid-read.** `rst=1` for 1 cycle, one cycle after a read grant → no `rsp_valid`; `ptr` restarts at 0.
